mdu_ctrl: RTL
=============

Name: mdu_ctrl

Overview:
- Multiply/divide unit with its own scheduler for the five-stage MIPS pipeline, placed in the E stage beside the ALU.
- Accepts mult/multu/div/divu/mthi/mtlo from E and owns the HI/LO registers.
- Models fixed multi-cycle latency with a busy counter.
- Produces the D-stage stall request so that no MDU instruction issues while HI/LO are pending.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  E-stage instruction is a valid MDU op; qualifies mdu_op
- mdu_op  in  4  operation code: NOP, MULT, MULTU, DIV, DIVU, MTHI, MTLO (+MADD, MADDU, MSUB, MSUBU with option)
- rs_data  in  32  forwarded operand A
- rt_data  in  32  forwarded operand B
- d_is_mdu  in  1  D-stage instruction uses the MDU (any MDU op, mfhi or mflo)
- hilo_sel  in  1  read select: 0 = LO, 1 = HI
- busy  out  1  multi-cycle operation in flight
- stall  out  1  D-stage stall request
- hi  out  32  HI register
- lo  out  32  LO register
- rd_data  out  32  hilo_sel ? hi : lo (combinational, used by mfhi/mflo in E)

Behaviour:
- Reset (sync, active-high): busy=0, counter=0, hi=0, lo=0, operand/op latches=0. Reset has priority over everything, including an operation in flight; that result is discarded.
- States:
  - IDLE (busy=0)
  - RUN (busy=1, counter counts down)
- IDLE, start with MULT/MULTU/DIV/DIVU:
  - latch rs_data, rt_data, op
  - load counter with MULT_CYCLES or DIV_CYCLES
  - go to RUN; busy=1 from the next cycle
- RUN: decrement counter each cycle. On the edge where counter==1:
  - write HI/LO
  - counter=0, busy=0 (back to IDLE)
  - new values are visible the cycle after the last busy cycle
  - busy is high for exactly N cycles, N = MULT_CYCLES or DIV_CYCLES.
- MTHI/MTLO in IDLE: hi (or lo) <= rs_data at the next edge; busy stays 0.
- Arithmetic:
  - MULT: signed 32x32->64, {hi,lo}=product
  - MULTU: unsigned 32x32->64
  - DIV: lo=quotient truncated toward zero, hi=remainder with the sign of the dividend
  - DIVU: unsigned quotient and remainder
  - 0x80000000 DIV 0xFFFFFFFF: lo=0x80000000, hi=0
- Divide by zero (DIV or DIVU): HI and LO keep their old values; busy still runs for DIV_CYCLES.
- stall = d_is_mdu & (busy | (start & mdu_op is a multi-cycle op)).
- start while busy: protocol violation that the stall logic prevents. The block ignores it (no latch, no HI/LO write, counter unaffected). The bench flags it with an assertion.
- start with NOP: no effect.
- hi, lo and rd_data reflect the registered values only; HI/LO are never bypassed.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - adds MADD/MADDU/MSUB/MSUBU with MULT_CYCLES latency
  - result {hi,lo} <= {hi,lo} ± product (signed or unsigned product), modulo 2^64
  - the {hi,lo} used is the value at completion time
- Undefined: these codes are treated as NOP and the accumulate datapath is not synthesised.

Decomposition:
- Shared macro header holds:
  - the mdu_op encodings (MDU_NOP=0, MDU_MULT=1, MDU_MULTU=2, MDU_DIV=3, MDU_DIVU=4, MDU_MTHI=5, MDU_MTLO=6, MDU_MADD=7, MDU_MADDU=8, MDU_MSUB=9, MDU_MSUBU=10)
  - the default cycle constants
- The control unit in D uses the same header to generate d_is_mdu.
- Natural sub-module: mdu_arith, a purely combinational 64-bit result computation (mul/div/acc) from the latched operands and op. mdu_ctrl keeps the FSM, counter and HI/LO.

Test Plan:
- After reset, start MULT with rs=0xFFFFFFFE (-2), rt=3 -> busy high for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- DIV with rs=-7 (0xFFFFFFF9), rt=2 -> 10 busy cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with the same operands -> lo=0x7FFFFFFC, hi=1.
- MTHI 0x1234 then MTLO 0x5678 on consecutive cycles -> busy never rises; hi=0x1234, lo=0x5678; rd_data follows hilo_sel.
- MULTU 0x10000 x 0x10000 with d_is_mdu=1 for the whole run -> stall high from the start cycle through the last busy cycle and low the cycle after; hi=1, lo=0.
- Preload hi=0xAA, lo=0xBB, then DIVU by 0 -> 10 busy cycles; hi=0xAA, lo=0xBB unchanged. Assert reset in cycle 3 of a MULT -> busy=0 and hi=lo=0 next cycle; no late write.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU 1x1 -> hi=1, lo=0. Without the macro, the same op -> no busy, HI/LO unchanged.

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: shared definitions for the multiply/divide unit.
// The mdu_op encodings are also used by the D-stage control unit to generate d_is_mdu.
// The optional accumulate ops (MADD/MADDU/MSUB/MSUBU) exist only when MDU_MADD_EN is defined.
package mdu_ctrl_pkg;

    // Operation codes carried on mdu_op
    localparam logic [3:0] MDU_NOP   = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MTHI  = 4'd5;
    localparam logic [3:0] MDU_MTLO  = 4'd6;
    localparam logic [3:0] MDU_MADD  = 4'd7;
    localparam logic [3:0] MDU_MADDU = 4'd8;
    localparam logic [3:0] MDU_MSUB  = 4'd9;
    localparam logic [3:0] MDU_MSUBU = 4'd10;

    // Default busy lengths
    localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
    localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;

    // Operands and op captured when a multi-cycle operation is issued
    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } mdu_req_t;

    // Accumulate ops are recognised only when the feature is built in;
    // otherwise their codes fall through as NOP everywhere.
    function automatic logic is_acc_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op == MDU_MADD) || (op == MDU_MADDU) ||
               (op == MDU_MSUB) || (op == MDU_MSUBU);
`else
        return (op != op);
`endif
    endfunction

    // Ops that use MULT_CYCLES latency
    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || is_acc_op(op);
    endfunction

    // Ops that use DIV_CYCLES latency
    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    // Ops that occupy the unit and hold HI/LO pending
    function automatic logic is_multi_cycle_op(input logic [3:0] op);
        return is_mul_op(op) || is_div_op(op);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 64-bit {hi,lo} result for the latched MDU operation.
// Signed divide is done on magnitudes so 0x80000000 / -1 yields 0x80000000 rem 0.
// Divide by zero returns the incoming {hi,lo}, so writing it back leaves HI/LO unchanged.
// Accumulate datapath present only with MDU_MADD_EN defined.
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    output logic [63:0] result
);

    logic        mul_signed;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;

    logic        div_signed;
    logic        neg_a;
    logic        neg_b;
    logic        div_zero;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] divisor;
    logic [31:0] mag_q;
    logic [31:0] mag_r;
    logic [31:0] quot;
    logic [31:0] rem;

    // 64-bit product; sign-extending both operands makes the truncated product correct for signed ops
    always_comb begin
        mul_signed = (op == MDU_MULT) || (op == MDU_MADD) || (op == MDU_MSUB);
        ext_a      = {{32{mul_signed & op_a[31]}}, op_a};
        ext_b      = {{32{mul_signed & op_b[31]}}, op_b};
        product    = ext_a * ext_b;
    end

    // Quotient/remainder: unsigned divide of magnitudes, then restore signs
    always_comb begin
        div_signed = (op == MDU_DIV);
        neg_a      = div_signed & op_a[31];
        neg_b      = div_signed & op_b[31];
        mag_a      = neg_a ? (32'd0 - op_a) : op_a;
        mag_b      = neg_b ? (32'd0 - op_b) : op_b;
        div_zero   = (op_b == 32'd0);
        divisor    = div_zero ? 32'd1 : mag_b;
        mag_q      = mag_a / divisor;
        mag_r      = mag_a % divisor;
        quot       = (neg_a ^ neg_b) ? (32'd0 - mag_q) : mag_q;
        rem        = neg_a ? (32'd0 - mag_r) : mag_r;
    end

    // Select the new {hi,lo}; anything unrecognised passes the current value through
    always_comb begin
        result = {hi_in, lo_in};
        case (op)
            MDU_MULT, MDU_MULTU: result = product;
            MDU_DIV, MDU_DIVU: begin
                if (!div_zero) begin
                    result = {rem, quot};
                end
            end
`ifdef MDU_MADD_EN
            MDU_MADD, MDU_MADDU: result = {hi_in, lo_in} + product;
            MDU_MSUB, MDU_MSUBU: result = {hi_in, lo_in} - product;
`endif
            default: result = {hi_in, lo_in};
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: E-stage multiply/divide unit with HI/LO ownership and D-stage stall generation.
// A busy counter models fixed latency: busy is high for exactly MULT_CYCLES or DIV_CYCLES cycles,
// HI/LO are written on the edge ending the last busy cycle.
// Optional macro MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU (MULT_CYCLES latency).
// CNT_W must be wide enough to hold max(MULT_CYCLES, DIV_CYCLES).
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF,
    parameter int unsigned CNT_W       = 4
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        d_is_mdu,
    input  logic        hilo_sel,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             state;
    logic [CNT_W-1:0] count;
    mdu_req_t         req;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [63:0]      result;
    logic             issue;
    logic             finish;
    logic             move_ok;
    logic [CNT_W-1:0] load_value;

    mdu_arith u_arith (
        .op     (req.op),
        .op_a   (req.a),
        .op_b   (req.b),
        .hi_in  (hi_q),
        .lo_in  (lo_q),
        .result (result)
    );

    // Issue/complete decode; starts while busy are ignored
    always_comb begin
        issue      = (state == ST_IDLE) & start & is_multi_cycle_op(mdu_op);
        move_ok    = (state == ST_IDLE) & start;
        finish     = (state == ST_RUN) & (count == CNT_ONE);
        load_value = is_div_op(mdu_op) ? DIV_LOAD : MULT_LOAD;
    end

    // FSM, busy counter and operand latch
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            count <= '0;
            req   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        req   <= '{op: mdu_op, a: rs_data, b: rt_data};
                        count <= load_value;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (finish) begin
                        count <= '0;
                        state <= ST_IDLE;
                    end else begin
                        count <= count - CNT_ONE;
                    end
                end
            endcase
        end
    end

    // HI/LO: completion writeback or IDLE-time moves from rs_data
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (finish) begin
            {hi_q, lo_q} <= result;
        end else if (move_ok) begin
            case (mdu_op)
                MDU_MTHI: hi_q <= rs_data;
                MDU_MTLO: lo_q <= rs_data;
                default: ;
            endcase
        end
    end

    // Outputs: registered HI/LO only, no bypass of pending results
    always_comb begin
        busy    = (state == ST_RUN);
        stall   = d_is_mdu & (busy | (start & is_multi_cycle_op(mdu_op)));
        hi      = hi_q;
        lo      = lo_q;
        rd_data = hilo_sel ? hi_q : lo_q;
    end

endmodule
